// File: rtl/branch_pkg.sv
// Shared types and constants for the branch sequencer slice.
package branch_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ALU = 2'd1,
      REDIRECT = 2'd2,
      FLUSH    = 2'd3
   } state_e;

   localparam logic BR_BEQ = 1'b0;
   localparam logic BR_BNE = 1'b1;

   localparam int CNT_W = 16;

endpackage

// File: rtl/branch_sequencer_if.sv
// Decode / ALU / PC signal bundle around the branch sequencer.
interface branch_sequencer_if #(
   parameter int ADDR_W = 32
);
   import branch_pkg::*;

   logic              br_valid;
   logic              br_ready;
   logic              br_is_bne;
   logic [ADDR_W-1:0] br_target;
   logic              alu_done;
   logic              alu_zero;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_target;
   logic              stall;
   logic              flush;
   logic              timeout_err;
   logic [CNT_W-1:0]  branch_cnt;
   logic [CNT_W-1:0]  taken_cnt;

   modport master (
      output br_valid, br_is_bne, br_target, alu_done, alu_zero,
      input  br_ready, pc_load, pc_target, stall, flush, timeout_err,
             branch_cnt, taken_cnt
   );

   modport slave (
      input  br_valid, br_is_bne, br_target, alu_done, alu_zero,
      output br_ready, pc_load, pc_target, stall, flush, timeout_err,
             branch_cnt, taken_cnt
   );

endinterface

// File: rtl/branch_sequencer_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter
   import branch_pkg::*;
#(
   parameter int WIDTH = CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign count = count_q;

endmodule

// File: rtl/branch_sequencer.sv
// Multicycle conditional-branch controller: stalls decode until the ALU
// compare resolves, then redirects the PC and flushes younger slots.
module branch_sequencer
   import branch_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int ALU_TIMEOUT  = 8
) (
   input logic               clk,
   input logic               rst_n,
   branch_sequencer_if.slave bus
);

   localparam logic [7:0] WAIT_LAST  = 8'(ALU_TIMEOUT - 1);
   localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

   state_e            state_q, state_d;
   logic [7:0]        waitCnt_q, waitCnt_d;
   logic [3:0]        flushCnt_q, flushCnt_d;
   logic              isBne_q, isBne_d;
   logic [ADDR_W-1:0] target_q, target_d;
   logic              timeoutErr_q, timeoutErr_d;
   logic              branchInc;
   logic              takenInc;
   logic              taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         waitCnt_q    <= '0;
         flushCnt_q   <= '0;
         isBne_q      <= 1'b0;
         target_q     <= '0;
         timeoutErr_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         waitCnt_q    <= waitCnt_d;
         flushCnt_q   <= flushCnt_d;
         isBne_q      <= isBne_d;
         target_q     <= target_d;
         timeoutErr_q <= timeoutErr_d;
      end
   end

   assign taken = bus.alu_zero ^ (isBne_q == BR_BNE);

   // alu_done takes priority over the timeout when both land in the same cycle
   always_comb begin
      state_d      = state_q;
      waitCnt_d    = waitCnt_q;
      flushCnt_d   = flushCnt_q;
      isBne_d      = isBne_q;
      target_d     = target_q;
      timeoutErr_d = timeoutErr_q;
      branchInc    = 1'b0;
      takenInc     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.br_valid) begin
               isBne_d   = bus.br_is_bne;
               target_d  = bus.br_target;
               waitCnt_d = '0;
               branchInc = 1'b1;
               state_d   = WAIT_ALU;
            end
         end
         WAIT_ALU: begin
            if (bus.alu_done) begin
               if (taken) begin
                  takenInc = 1'b1;
                  state_d  = REDIRECT;
               end else begin
                  state_d = IDLE;
               end
            end else if (waitCnt_q == WAIT_LAST) begin
               timeoutErr_d = 1'b1;
               state_d      = IDLE;
            end else begin
               waitCnt_d = waitCnt_q + 8'd1;
            end
         end
         REDIRECT: begin
            if (FLUSH_CYCLES > 0) begin
               flushCnt_d = FLUSH_LOAD;
               state_d    = FLUSH;
            end else begin
               state_d = IDLE;
            end
         end
         FLUSH: begin
            if (flushCnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               flushCnt_d = flushCnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.br_ready    = (state_q == IDLE);
   assign bus.stall       = (state_q == WAIT_ALU);
   assign bus.pc_load     = (state_q == REDIRECT);
   assign bus.flush       = (state_q == REDIRECT) || (state_q == FLUSH);
   assign bus.pc_target   = target_q;
   assign bus.timeout_err = timeoutErr_q;

   sat_counter #(.WIDTH(CNT_W)) uBranchCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (branchInc),
      .count (bus.branch_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) uTakenCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (takenInc),
      .count (bus.taken_cnt)
   );

endmodule
